// File: rtl/toy_cpu_issuer.sv
// Instruction front-end: packs a 3-byte serial stream into 20-bit instructions,
// queues them in a small FIFO and issues one per cycle while issue_en is high.
module toy_cpu_issuer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready,
    input  logic          issue_en,
    input  logic          flush,
    output logic          op_valid,
    output logic [2:0]    opcode,
    output logic [2:0]    src_a,
    output logic [2:0]    src_b,
    output logic [2:0]    dest,
    output logic [7:0]    imm,
    output logic [CW-1:0] fifo_count,
    output logic          asm_busy
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2
    } asm_state_t;

    asm_state_t    state_q, state_d;
    logic [2:0]    opc_lat_q, opc_lat_d;
    logic [2:0]    sa_lat_q, sa_lat_d;
    logic [2:0]    sb_lat_q, sb_lat_d;
    logic [2:0]    dst_lat_q, dst_lat_d;

    logic [19:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          op_valid_q, op_valid_d;
    logic [19:0]   out_q, out_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [19:0]   push_word;

    assign in_ready = rst && (count_q < DEPTH_C);

    // flush suppresses both the byte accept and the pop in its cycle
    always_comb begin
        accept    = in_valid && in_ready && !flush;
        push      = accept && (state_q == BYTE2);
        pop       = issue_en && (count_q != '0) && !flush;
        push_word = {opc_lat_q, sa_lat_q, sb_lat_q, dst_lat_q, in_byte};

        state_d    = state_q;
        opc_lat_d  = opc_lat_q;
        sa_lat_d   = sa_lat_q;
        sb_lat_d   = sb_lat_q;
        dst_lat_d  = dst_lat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        op_valid_d = pop;

        if (accept) begin
            case (state_q)
                BYTE0: begin
                    opc_lat_d = in_byte[7:5];
                    sa_lat_d  = in_byte[4:2];
                    state_d   = BYTE1;
                end
                BYTE1: begin
                    sb_lat_d  = in_byte[7:5];
                    dst_lat_d = in_byte[4:2];
                    state_d   = BYTE2;
                end
                default: state_d = BYTE0;
            endcase
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            out_d    = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            state_d  = BYTE0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BYTE0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_valid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_valid_q <= op_valid_d;
            out_q      <= out_d;
        end
    end

    // Field latches and FIFO storage carry data only; no reset needed
    always_ff @(posedge clk) begin
        opc_lat_q <= opc_lat_d;
        sa_lat_q  <= sa_lat_d;
        sb_lat_q  <= sb_lat_d;
        dst_lat_q <= dst_lat_d;
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign op_valid   = op_valid_q;
    assign opcode     = out_q[19:17];
    assign src_a      = out_q[16:14];
    assign src_b      = out_q[13:11];
    assign dest       = out_q[10:8];
    assign imm        = out_q[7:0];
    assign fifo_count = count_q;
    assign asm_busy   = (state_q != BYTE0);

endmodule

// File: tb/tb_toy_cpu_issuer.sv
// Directed bench for toy_cpu_issuer: vector table plus hand-written
// sequences for pointer wrap, flush and reset corner cases.
module tb_toy_cpu_issuer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          issue_en;
    logic          flush;
    logic          op_valid;
    logic [2:0]    opcode;
    logic [2:0]    src_a;
    logic [2:0]    src_b;
    logic [2:0]    dest;
    logic [7:0]    imm;
    logic [CW-1:0] fifo_count;
    logic          asm_busy;
    logic [19:0]   fields;

    always #5 clk = ~clk;

    toy_cpu_issuer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .issue_en   (issue_en),
        .flush      (flush),
        .op_valid   (op_valid),
        .opcode     (opcode),
        .src_a      (src_a),
        .src_b      (src_b),
        .dest       (dest),
        .imm        (imm),
        .fifo_count (fifo_count),
        .asm_busy   (asm_busy)
    );

    assign fields = {opcode, src_a, src_b, dest, imm};

    typedef struct {
        logic          rst;
        logic          iv;
        logic [7:0]    b;
        logic          ie;
        logic          fl;
        logic          ev;
        logic [19:0]   ef;
        logic [CW-1:0] ec;
        logic          er;
        logic          eb;
    } vec_t;

    vec_t        tbl[$];
    logic [19:0] exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [19:0] fld(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2);
        return {b0[7:5], b0[4:2], b1[7:5], b1[4:2], b2};
    endfunction

    function automatic logic [7:0] ib(input int k, input int j);
        return 8'((k * 37 + j * 91 + 13) & 255);
    endfunction

    function automatic logic [19:0] fk(input int k);
        return fld(ib(k, 0), ib(k, 1), ib(k, 2));
    endfunction

    function automatic vec_t v(input logic r, input logic iv, input logic [7:0] b,
                               input logic ie, input logic fl, input logic ev,
                               input logic [19:0] ef, input int ec, input logic er,
                               input logic eb);
        vec_t t;
        t.rst = r;  t.iv = iv; t.b = b;   t.ie = ie; t.fl = fl;
        t.ev  = ev; t.ef = ef; t.ec = CW'(ec); t.er = er; t.eb = eb;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [7:0] b,
                         input logic ie, input logic fl);
        rst      = r;
        in_valid = iv;
        in_byte  = b;
        issue_en = ie;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [19:0] ef,
                              input logic [CW-1:0] ec, input logic er, input logic eb);
        check({tag, "_op_valid"}, 32'(op_valid), 32'(ev));
        check({tag, "_fields"}, 32'(fields), 32'(ef));
        check({tag, "_count"}, 32'(fifo_count), 32'(ec));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(er));
        check({tag, "_asm_busy"}, 32'(asm_busy), 32'(eb));
    endtask

    initial begin
        logic [19:0] f1;
        logic [19:0] last_f;
        logic        ie_now;
        int          cnt;

        rst = 1'b0; in_valid = 1'b0; in_byte = '0; issue_en = 1'b0; flush = 1'b0;
        f1 = fld(8'hA4, 8'h6C, 8'h5A);

        // reset held two cycles, a byte offered during reset is ignored
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 20'h0, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'hFF, 1, 0, 0, 20'h0, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 1, 0, 0, 20'h0, 0, 1, 0));
        // single instruction, issue_en held high
        tbl.push_back(v(1, 1, 8'hA4, 1, 0, 0, 20'h0, 0, 1, 1));
        tbl.push_back(v(1, 1, 8'h6C, 1, 0, 0, 20'h0, 0, 1, 1));
        tbl.push_back(v(1, 1, 8'h5A, 1, 0, 0, 20'h0, 1, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 1, 0, 1, f1, 0, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 1, 0, 0, f1, 0, 1, 0));
        // fill to DEPTH with issue disabled
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                cnt = (j == 2) ? k + 1 : k;
                tbl.push_back(v(1, 1, ib(k, j), 0, 0, 0, f1, cnt, cnt < 4, j != 2));
            end
        end
        tbl.push_back(v(1, 1, ib(4, 0), 0, 0, 0, f1, 4, 0, 0));
        tbl.push_back(v(1, 1, ib(4, 0), 0, 0, 0, f1, 4, 0, 0));
        // drain with the fifth instruction streamed in behind
        tbl.push_back(v(1, 1, ib(4, 0), 1, 0, 1, fk(0), 3, 1, 0));
        tbl.push_back(v(1, 1, ib(4, 0), 1, 0, 1, fk(1), 2, 1, 1));
        tbl.push_back(v(1, 1, ib(4, 1), 1, 0, 1, fk(2), 1, 1, 1));
        tbl.push_back(v(1, 1, ib(4, 2), 1, 0, 1, fk(3), 1, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 1, 0, 1, fk(4), 0, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 1, 0, 0, fk(4), 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].b, tbl[i].ie, tbl[i].fl);
            expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ef, tbl[i].ec,
                       tbl[i].er, tbl[i].eb);
        end

        // steady count of 2 with push and pop on the same edge, across pointer wrap
        for (int n = 0; n < 10; n++) begin
            for (int j = 0; j < 3; j++) begin
                ie_now = (n >= 2) && (j == 2);
                drive(1, 1, ib(n + 10, j), ie_now, 0);
                check("wrap_op_valid", 32'(op_valid), 32'(ie_now));
                if (ie_now) check("wrap_fields", 32'(fields), 32'(exp_q.pop_front()));
                if (j == 2) begin
                    exp_q.push_back(fk(n + 10));
                    check("wrap_count", 32'(fifo_count), (n < 2) ? 32'(n + 1) : 32'd2);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            drive(1, 0, 8'h00, 1, 0);
            check("drain_op_valid", 32'(op_valid), 32'd1);
            check("drain_fields", 32'(fields), 32'(exp_q.pop_front()));
        end
        check("drain_count", 32'(fifo_count), 32'd0);
        last_f = fk(19);

        // flush with two queued and a partial instruction, byte offered in flush cycle
        for (int n = 0; n < 2; n++)
            for (int j = 0; j < 3; j++) drive(1, 1, ib(n + 30, j), 0, 0);
        check("pre_flush_count", 32'(fifo_count), 32'd2);
        drive(1, 1, 8'h11, 0, 0);
        drive(1, 1, 8'h22, 0, 0);
        check("pre_flush_busy", 32'(asm_busy), 32'd1);
        drive(1, 1, 8'h33, 1, 1);
        expect_out("flush", 1'b0, last_f, 0, 1'b1, 1'b0);
        drive(1, 1, 8'hE8, 1, 0);
        drive(1, 1, 8'h94, 1, 0);
        drive(1, 1, 8'hC3, 1, 0);
        expect_out("post_flush_push", 1'b0, last_f, 1, 1'b1, 1'b0);
        drive(1, 0, 8'h00, 1, 0);
        expect_out("post_flush_issue", 1'b1, fld(8'hE8, 8'h94, 8'hC3), 0, 1'b1, 1'b0);

        // reset while an issue is visible and three entries are queued
        for (int n = 0; n < 3; n++)
            for (int j = 0; j < 3; j++) drive(1, 1, ib(n + 40, j), 0, 0);
        drive(1, 1, ib(43, 0), 0, 0);
        drive(1, 1, ib(43, 1), 0, 0);
        drive(1, 1, ib(43, 2), 1, 0);
        expect_out("pre_reset", 1'b1, fk(40), 3, 1'b1, 1'b0);
        drive(0, 1, 8'h55, 1, 0);
        expect_out("mid_reset", 1'b0, 20'h0, 0, 1'b0, 1'b0);

        // reset in the middle of an instruction discards the partial byte
        drive(1, 1, 8'hA0, 0, 0);
        check("partial_busy", 32'(asm_busy), 32'd1);
        drive(0, 0, 8'h00, 0, 0);
        check("partial_reset_busy", 32'(asm_busy), 32'd0);
        drive(1, 0, 8'h00, 0, 0);
        drive(1, 1, 8'h4C, 0, 0);
        drive(1, 1, 8'hB8, 0, 0);
        drive(1, 1, 8'h07, 0, 0);
        expect_out("after_reset_push", 1'b0, 20'h0, 1, 1'b1, 1'b0);
        drive(1, 0, 8'h00, 1, 0);
        expect_out("after_reset_issue", 1'b1, fld(8'h4C, 8'hB8, 8'h07), 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
